// File: rtl/sprite_pkg.sv
// Shared types and the per-axis step/reflect helper
// for the bounce sprite engine.
package sprite_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  typedef enum logic {
    IDLE,
    UPDATE
  } state_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       dir_x;
    logic       dir_y;
  } ball_t;

  typedef struct packed {
    logic [9:0] pos;
    logic       dir;
    logic       reflect;
  } axis_t;

  // Compared at 11 bits so pos+step can never wrap past the limit.
  function automatic axis_t axis_step(
    input logic [9:0] pos,
    input logic       dir,
    input logic [9:0] step,
    input logic [9:0] lo,
    input logic [9:0] hi
  );
    axis_t      r;
    logic [10:0] up;
    logic [10:0] lo_step;
    up      = {1'b0, pos} + {1'b0, step};
    lo_step = {1'b0, lo} + {1'b0, step};
    r.pos     = pos;
    r.dir     = dir;
    r.reflect = 1'b0;
    if (dir) begin
      if (up >= {1'b0, hi}) begin
        r.pos     = hi;
        r.dir     = 1'b0;
        r.reflect = 1'b1;
      end else begin
        r.pos = up[9:0];
      end
    end else begin
      if ({1'b0, pos} <= lo_step) begin
        r.pos     = lo;
        r.dir     = 1'b1;
        r.reflect = 1'b1;
      end else begin
        r.pos = pos - step;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bounce_sprite_engine_dist.sv
// Per-ball pixel distance: S1 registers |dx|,|dy|,
// combinational sum of squares and radius compares feed S2.
module ball_dist_sq
  import sprite_pkg::*;
#(
  parameter int RADIUS   = 20,
  parameter int SHADOW_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       in_ball,
  output logic       in_shadow
);

  localparam logic [20:0] R_SQ =
    21'(RADIUS * RADIUS);
  localparam logic [20:0] S_SQ =
    21'((RADIUS + SHADOW_W) * (RADIUS + SHADOW_W));

  logic [9:0]  dx;
  logic [9:0]  dy;
  logic [20:0] d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dx <= '0;
      dy <= '0;
    end else begin
      dx <= (hpos >= x) ? hpos - x : x - hpos;
      dy <= (vpos >= y) ? vpos - y : y - vpos;
    end
  end

  assign d = 21'(dx) * 21'(dx) + 21'(dy) * 21'(dy);

  assign in_ball   = (d <= R_SQ);
  assign in_shadow = (d <= S_SQ);

endmodule

// File: rtl/bounce_sprite_engine.sv
// Multi-ball bouncer: one shared update path walks the balls once
// per frame; a 2-stage pipeline reports ball/shadow hits per pixel.
module bounce_sprite_engine
  import sprite_pkg::*;
#(
  parameter int NUM_BALLS = 4,
  parameter int RADIUS    = 20,
  parameter int SHADOW_W  = 4,
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int BASE_STEP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        pause,
  input  logic [1:0]  speed_sel,
  input  logic [9:0]  hpos,
  input  logic [9:0]  vpos,
  input  logic        display_on,
  output logic        ball_hit,
  output logic        shadow_hit,
  output logic [2:0]  hit_id,
  output logic [15:0] bounce_count,
  output logic        update_busy
);

  localparam int IDW = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;

  localparam logic [9:0] X_MIN = 10'(RADIUS);
  localparam logic [9:0] X_MAX = 10'(H_ACTIVE - 1 - RADIUS);
  localparam logic [9:0] Y_MIN = 10'(RADIUS);
  localparam logic [9:0] Y_MAX = 10'(V_ACTIVE - 1 - RADIUS);

  function automatic ball_t init_ball(input int i);
    ball_t b;
    b.x     = 10'(RADIUS + 8 + i * (2 * RADIUS + 8));
    b.y     = 10'(V_ACTIVE / 2);
    b.dir_x = ~i[0];
    b.dir_y = ~i[1];
    return b;
  endfunction

  state_t         state;
  state_t         state_nx;
  logic [IDW-1:0] idx;
  logic [IDW-1:0] idx_nx;
  logic           start;
  logic [1:0]     spd;

  ball_t          balls [NUM_BALLS];
  ball_t          cur;
  ball_t          nb;
  axis_t          ax;
  axis_t          ay;
  logic [9:0]     step;
  logic [1:0]     inc;
  logic [16:0]    bc_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      spd   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      if (start) spd <= speed_sel;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    start    = 1'b0;
    unique case (state)
      IDLE: begin
        if (frame_start && !pause) begin
          state_nx = UPDATE;
          idx_nx   = '0;
          start    = 1'b1;
        end
      end
      UPDATE: begin
        idx_nx = idx + 1'b1;
        if (idx == IDW'(NUM_BALLS - 1)) begin
          state_nx = IDLE;
          idx_nx   = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign update_busy = (state == UPDATE);

  // Shared step/reflect datapath, muxed onto the ball selected by idx.
  always_comb begin
    cur = balls[0];
    for (int i = 0; i < NUM_BALLS; i++)
      if (idx == IDW'(i)) cur = balls[i];
    step     = 10'(BASE_STEP) << spd;
    ax       = axis_step(cur.x, cur.dir_x, step, X_MIN, X_MAX);
    ay       = axis_step(cur.y, cur.dir_y, step, Y_MIN, Y_MAX);
    nb.x     = ax.pos;
    nb.y     = ay.pos;
    nb.dir_x = ax.dir;
    nb.dir_y = ay.dir;
    inc      = {1'b0, ax.reflect} + {1'b0, ay.reflect};
    bc_sum   = {1'b0, bounce_count} + 17'(inc);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BALLS; i++)
        balls[i] <= init_ball(i);
      bounce_count <= '0;
    end else if (state == UPDATE) begin
      for (int i = 0; i < NUM_BALLS; i++)
        if (idx == IDW'(i)) balls[i] <= nb;
      bounce_count <= bc_sum[16] ? 16'hFFFF : bc_sum[15:0];
    end
  end

  logic [NUM_BALLS-1:0] in_v;
  logic [NUM_BALLS-1:0] sh_v;

  for (genvar g = 0; g < NUM_BALLS; g++) begin : g_ball
    ball_dist_sq #(
      .RADIUS   (RADIUS),
      .SHADOW_W (SHADOW_W)
    ) u_dist (
      .clk       (clk),
      .reset     (reset),
      .hpos      (hpos),
      .vpos      (vpos),
      .x         (balls[g].x),
      .y         (balls[g].y),
      .in_ball   (in_v[g]),
      .in_shadow (sh_v[g])
    );
  end

  logic       any_in;
  logic       any_sh;
  logic [2:0] id_in;
  logic [2:0] id_sh;
  logic       disp_s1;

  // Descending scan leaves the lowest-numbered hit in the id.
  always_comb begin
    any_in = 1'b0;
    any_sh = 1'b0;
    id_in  = '0;
    id_sh  = '0;
    for (int i = NUM_BALLS - 1; i >= 0; i--) begin
      if (in_v[i]) begin
        any_in = 1'b1;
        id_in  = 3'(i);
      end
      if (sh_v[i]) begin
        any_sh = 1'b1;
        id_sh  = 3'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_s1    <= 1'b0;
      ball_hit   <= 1'b0;
      shadow_hit <= 1'b0;
      hit_id     <= '0;
    end else begin
      disp_s1    <= display_on;
      ball_hit   <= disp_s1 & any_in;
      shadow_hit <= disp_s1 & ~any_in & any_sh;
      if (!disp_s1)
        hit_id <= '0;
      else if (any_in)
        hit_id <= id_in;
      else if (any_sh)
        hit_id <= id_sh;
      else
        hit_id <= '0;
    end
  end

endmodule

// File: tb/tb_bounce_sprite_engine.sv
// Directed bench for bounce_sprite_engine: default 4-ball instance
// plus a narrow single-ball instance that reaches a corner.
module tb_bounce_sprite_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        frame_start_c;
  logic        pause;
  logic [1:0]  speed_sel;
  logic [9:0]  hpos;
  logic [9:0]  vpos;
  logic        display_on;

  logic        ball_hit;
  logic        shadow_hit;
  logic [2:0]  hit_id;
  logic [15:0] bounce_count;
  logic        update_busy;

  logic        ball_hit_c;
  logic        shadow_hit_c;
  logic [2:0]  hit_id_c;
  logic [15:0] bounce_count_c;
  logic        update_busy_c;

  int n_chk  = 0;
  int n_pass = 0;
  int busy;

  always #5 clk = ~clk;

  bounce_sprite_engine dut (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .pause        (pause),
    .speed_sel    (speed_sel),
    .hpos         (hpos),
    .vpos         (vpos),
    .display_on   (display_on),
    .ball_hit     (ball_hit),
    .shadow_hit   (shadow_hit),
    .hit_id       (hit_id),
    .bounce_count (bounce_count),
    .update_busy  (update_busy)
  );

  // XMAX = 268-1-20 = 247, so from x=28 and y=240 at step 8
  // both axes hit their maxima on the same update.
  bounce_sprite_engine #(
    .NUM_BALLS (1),
    .H_ACTIVE  (268)
  ) dut_c (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (frame_start_c),
    .pause        (pause),
    .speed_sel    (speed_sel),
    .hpos         (hpos),
    .vpos         (vpos),
    .display_on   (display_on),
    .ball_hit     (ball_hit_c),
    .shadow_hit   (shadow_hit_c),
    .hit_id       (hit_id_c),
    .bounce_count (bounce_count_c),
    .update_busy  (update_busy_c)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic frame(
    input  bit         c,
    input  logic [1:0] spd,
    output int         nbusy
  );
    speed_sel = spd;
    if (c) frame_start_c = 1'b1;
    else   frame_start   = 1'b1;
    @(posedge clk); #1;
    frame_start   = 1'b0;
    frame_start_c = 1'b0;
    nbusy = 0;
    for (int k = 0; k < 20; k++) begin
      if (c ? update_busy_c : update_busy) nbusy++;
      @(posedge clk); #1;
    end
  endtask

  task automatic pix(
    input logic [9:0] h,
    input logic [9:0] v,
    input logic       d
  );
    hpos       = h;
    vpos       = v;
    display_on = d;
    repeat (2) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_pix(
    input string      tag,
    input logic       b,
    input logic       s,
    input logic [2:0] id
  );
    chk({tag, "_ball"}, ball_hit, b);
    chk({tag, "_shad"}, shadow_hit, s);
    chk({tag, "_id"}, hit_id, id);
  endtask

  initial begin
    reset         = 1'b1;
    frame_start   = 1'b0;
    frame_start_c = 1'b0;
    pause         = 1'b0;
    speed_sel     = 2'd0;
    hpos          = '0;
    vpos          = '0;
    display_on    = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    chk("rst_b0x", dut.balls[0].x, 28);
    chk("rst_b0y", dut.balls[0].y, 240);
    chk("rst_b0dx", dut.balls[0].dir_x, 1);
    chk("rst_b0dy", dut.balls[0].dir_y, 1);
    chk("rst_b1x", dut.balls[1].x, 76);
    chk("rst_b1dx", dut.balls[1].dir_x, 0);
    chk("rst_b1dy", dut.balls[1].dir_y, 1);
    chk("rst_b3x", dut.balls[3].x, 172);
    chk("rst_bc", bounce_count, 0);
    chk("rst_busy", update_busy, 0);
    chk_pix("rst", 0, 0, 0);

    reset = 1'b0;
    @(posedge clk); #1;

    // single-ball corner: 27 steps of 8 reach (244,456)
    for (int f = 0; f < 27; f++) frame(1, 2'd3, busy);
    chk("c_busy", busy, 1);
    chk("c_x_pre", dut_c.balls[0].x, 244);
    chk("c_y_pre", dut_c.balls[0].y, 456);
    chk("c_bc_pre", bounce_count_c, 0);
    frame(1, 2'd3, busy);
    chk("c_x", dut_c.balls[0].x, 247);
    chk("c_y", dut_c.balls[0].y, 459);
    chk("c_dx", dut_c.balls[0].dir_x, 0);
    chk("c_dy", dut_c.balls[0].dir_y, 0);
    chk("c_bc", bounce_count_c, 2);
    chk("c_outs", {ball_hit_c, shadow_hit_c, hit_id_c}, 0);

    frame(0, 2'd0, busy);
    chk("f1_busy", busy, 4);
    chk("f1_b0x", dut.balls[0].x, 29);
    chk("f1_b0y", dut.balls[0].y, 241);
    chk("f1_b1x", dut.balls[1].x, 75);

    // after 24 frames balls 0/1 share (52,264), balls 2/3 share (148,216)
    for (int f = 0; f < 23; f++) frame(0, 2'd0, busy);
    chk("f24_b1x", dut.balls[1].x, 52);
    chk("f24_b2x", dut.balls[2].x, 148);
    chk("f24_b3y", dut.balls[3].y, 216);

    pix(10'd300, 10'd100, 1'b1);
    chk_pix("miss", 0, 0, 0);

    hpos       = 10'd52;
    vpos       = 10'd264;
    display_on = 1'b1;
    @(posedge clk); #1;
    chk("lat1_ball", ball_hit, 0);
    @(posedge clk); #1;
    chk_pix("ctr01", 1, 0, 0);

    pix(10'd72, 10'd264, 1'b1);
    chk_pix("edge_r", 1, 0, 0);
    pix(10'd76, 10'd264, 1'b1);
    chk_pix("edge_sh", 0, 1, 0);
    pix(10'd74, 10'd264, 1'b1);
    chk_pix("sh22", 0, 1, 0);
    pix(10'd77, 10'd264, 1'b1);
    chk_pix("out25", 0, 0, 0);
    pix(10'd148, 10'd216, 1'b1);
    chk_pix("ctr23", 1, 0, 2);
    pix(10'd170, 10'd216, 1'b1);
    chk_pix("sh23", 0, 1, 2);
    pix(10'd52, 10'd264, 1'b0);
    chk_pix("blank", 0, 0, 0);

    for (int f = 0; f < 31; f++) frame(0, 2'd0, busy);
    chk("f55_b1x", dut.balls[1].x, 21);
    chk("f55_bc", bounce_count, 0);
    frame(0, 2'd0, busy);
    chk("f56_b1x", dut.balls[1].x, 20);
    chk("f56_b1dx", dut.balls[1].dir_x, 1);
    chk("f56_bc", bounce_count, 1);
    frame(0, 2'd0, busy);
    chk("f57_b1x", dut.balls[1].x, 21);
    chk("f57_bc", bounce_count, 1);
    chk("f57_b0x", dut.balls[0].x, 85);

    pause = 1'b1;
    frame(0, 2'd0, busy);
    chk("pause_busy", busy, 0);
    chk("pause_b0x", dut.balls[0].x, 85);
    pause = 1'b0;

    // second pulse lands while idx=1 and must not extend the pass
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    busy = 0;
    for (int k = 0; k < 12; k++) begin
      if (update_busy) busy++;
      frame_start = (k == 1);
      @(posedge clk); #1;
    end
    frame_start = 1'b0;
    chk("extra_busy", busy, 4);
    chk("extra_b0x", dut.balls[0].x, 86);
    chk("extra_b1x", dut.balls[1].x, 22);

    pix(10'd86, 10'd298, 1'b1);
    chk_pix("pre_rst", 1, 0, 0);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("mid_idx", dut.idx, 2);
    chk("mid_busy", update_busy, 1);
    reset = 1'b1;
    #1;
    chk("mrst_busy", update_busy, 0);
    chk("mrst_b0x", dut.balls[0].x, 28);
    chk("mrst_b0y", dut.balls[0].y, 240);
    chk("mrst_b1x", dut.balls[1].x, 76);
    chk("mrst_b1dx", dut.balls[1].dir_x, 0);
    chk("mrst_bc", bounce_count, 0);
    chk_pix("mrst", 0, 0, 0);
    display_on = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    frame(0, 2'd0, busy);
    chk("post_busy", busy, 4);
    chk("post_b0x", dut.balls[0].x, 29);
    chk("post_b0y", dut.balls[0].y, 241);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
